// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD sequencer.
// Holds the FSM state enums, the fixed command/character bytes and two
// small helpers: the init command ROM and the hex-digit to ASCII encoder.
package lcd_pkg;

   // Top-level sequencer states
   typedef enum logic [2:0] {
      IDLE,
      INIT,
      READY,
      ADDR,
      DATA
   } state_t;

   // Per-byte strobe phases inside lcd_xfer
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_HIGH,
      PH_HOLD
   } xfer_phase_t;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_DISP_ON    = 8'h0E;  // display on, cursor on
   localparam logic [7:0] CMD_CLEAR      = 8'h01;  // clear display (slow command)
   localparam logic [7:0] CMD_SET_ADDR   = 8'h80;  // DDRAM address 0
   localparam logic [7:0] CHR_SPACE      = 8'h20;
   localparam logic [7:0] DB_IDLE        = 8'hCC;  // bus value between transfers

   localparam int INIT_LEN = 4;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      logic [7:0] cmd;
      case (idx)
         3'd0:    cmd = CMD_FUNC_SET;
         3'd1:    cmd = CMD_ENTRY_MODE;
         3'd2:    cmd = CMD_DISP_ON;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

   // 0-9 -> '0'..'9', A-F -> 'A'..'F'
   function automatic logic [7:0] hex_char(input logic [3:0] v);
      logic [7:0] c;
      if (v < 4'd10) c = 8'h30 + {4'h0, v};
      else           c = 8'h41 + {4'h0, v - 4'd10};
      return c;
   endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte LCD write strobe generator.
// On go (while idle) it latches byte/rs onto the bus, holds E low for
// SETUP_CYC cycles, E high for E_CYC cycles, then E low for WAIT_CYC cycles
// (CLR_WAIT_CYC after a clear command) before returning the bus to DB_IDLE
// and pulsing ack. DB/RS never change while a byte is in flight.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   go                one-cycle request, accepted only when idle
//   tx_byte, tx_rs    byte and register select to send
//   lcd_e/rs/db       LCD pins (registered)
//   ack               one-cycle pulse when the byte's wait time has elapsed
module lcd_xfer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC    = 2,
   parameter int E_CYC        = 12,
   parameter int WAIT_CYC     = 2000,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic [7:0] tx_byte,
   input  logic       tx_rs,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_db,
   output logic       ack
);

   xfer_phase_t phase;
   logic [31:0] cnt;
   logic        is_clear;

   // The bus already holds the byte in flight, so decide the wait from it.
   assign is_clear = (lcd_db == CMD_CLEAR) && !lcd_rs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase  <= PH_IDLE;
         cnt    <= '0;
         lcd_e  <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_db <= DB_IDLE;
         ack    <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (phase)
            PH_IDLE: begin
               if (go) begin
                  lcd_db <= tx_byte;
                  lcd_rs <= tx_rs;
                  cnt    <= 32'(SETUP_CYC - 1);
                  phase  <= PH_SETUP;
               end
            end
            PH_SETUP: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt   <= 32'(E_CYC - 1);
                  phase <= PH_HIGH;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            PH_HIGH: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b0;
                  cnt   <= is_clear ? 32'(CLR_WAIT_CYC - 1) : 32'(WAIT_CYC - 1);
                  phase <= PH_HOLD;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            PH_HOLD: begin
               if (cnt == '0) begin
                  lcd_db <= DB_IDLE;
                  lcd_rs <= 1'b0;
                  ack    <= 1'b1;
                  phase  <= PH_IDLE;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: phase <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_seq.sv
// LCD init + hex-digit refresh sequencer.
// start runs the four-command init; update (once ready) writes the
// DDRAM address followed by NUM_DIGITS ASCII hex characters, leftmost first.
// Updates arriving while a sequence runs collapse into one pending refresh
// that starts as soon as the sequencer is back in READY.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, update    one-cycle request pulses
//   digits           packed nibbles, top nibble = leftmost character
//   busy, ready      status (registered)
//   done             one-cycle pulse at the end of init or refresh
//   lcd_e/rs/rw/db   LCD pins; rw is always write
module lcd_seq
   import lcd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SETUP_CYC    = 2,
   parameter int E_CYC        = 12,
   parameter int WAIT_CYC     = 2000,
   parameter int CLR_WAIT_CYC = 82000,
   parameter int LZ_BLANK     = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    update,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic                    busy,
   output logic                    ready,
   output logic                    done,
   output logic                    lcd_e,
   output logic                    lcd_rs,
   output logic                    lcd_rw,
   output logic [7:0]              lcd_db
);

   state_t                  state;
   logic [2:0]              idx;
   logic [4*NUM_DIGITS-1:0] digits_lat;
   logic                    pending;
   logic                    go;
   logic [7:0]              tx_byte;
   logic                    tx_rs;
   logic                    ack;

   logic [7:0]              char_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [2:0]              char_sel;
   logic [7:0]              next_char;

   assign lcd_rw = 1'b0;

   // Character for each position. lead_zero[p] is set when every digit from
   // the left edge through position p is zero; the rightmost position is
   // never blanked so an all-zero value still shows a single '0'.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_char
      localparam bit BLANK_OK = (LZ_BLANK != 0) && (gi != NUM_DIGITS - 1);
      logic [3:0] nib;
      assign nib = digits_lat[4*(NUM_DIGITS-1-gi) +: 4];
      if (gi == 0) begin : g_first
         assign lead_zero[gi] = (nib == 4'h0);
      end else begin : g_rest
         assign lead_zero[gi] = lead_zero[gi-1] && (nib == 4'h0);
      end
      assign char_arr[gi] = (BLANK_OK && lead_zero[gi]) ? CHR_SPACE : hex_char(nib);
   end

   // Character to issue on the next ack: first digit after the address
   // byte, otherwise the one after the digit currently on the bus.
   always_comb begin
      char_sel  = (state == DATA) ? idx + 3'd1 : 3'd0;
      next_char = char_arr[0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (char_sel == 3'(i)) next_char = char_arr[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         digits_lat <= '0;
         pending    <= 1'b0;
         go         <= 1'b0;
         tx_byte    <= DB_IDLE;
         tx_rs      <= 1'b0;
         busy       <= 1'b0;
         ready      <= 1'b0;
         done       <= 1'b0;
      end else begin
         go   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE, READY: begin
               // start beats update and flushes anything pending
               if (start) begin
                  state   <= INIT;
                  idx     <= '0;
                  pending <= 1'b0;
                  go      <= 1'b1;
                  tx_byte <= init_cmd(3'd0);
                  tx_rs   <= 1'b0;
                  busy    <= 1'b1;
               end else if (state == READY && (update || pending)) begin
                  state      <= ADDR;
                  digits_lat <= digits;
                  pending    <= 1'b0;
                  go         <= 1'b1;
                  tx_byte    <= CMD_SET_ADDR;
                  tx_rs      <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            INIT: begin
               if (update) pending <= 1'b1;
               if (ack) begin
                  if (idx == 3'(INIT_LEN - 1)) begin
                     state <= READY;
                     ready <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     idx     <= idx + 3'd1;
                     go      <= 1'b1;
                     tx_byte <= init_cmd(idx + 3'd1);
                  end
               end
            end
            ADDR: begin
               if (update) pending <= 1'b1;
               if (ack) begin
                  state   <= DATA;
                  idx     <= '0;
                  go      <= 1'b1;
                  tx_byte <= next_char;
                  tx_rs   <= 1'b1;
               end
            end
            DATA: begin
               if (update) pending <= 1'b1;
               if (ack) begin
                  if (idx == 3'(NUM_DIGITS - 1)) begin
                     state <= READY;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     idx     <= idx + 3'd1;
                     go      <= 1'b1;
                     tx_byte <= next_char;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   lcd_xfer #(
      .SETUP_CYC   (SETUP_CYC),
      .E_CYC       (E_CYC),
      .WAIT_CYC    (WAIT_CYC),
      .CLR_WAIT_CYC(CLR_WAIT_CYC)
   ) u_xfer (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .tx_byte(tx_byte),
      .tx_rs  (tx_rs),
      .lcd_e  (lcd_e),
      .lcd_rs (lcd_rs),
      .lcd_db (lcd_db),
      .ack    (ack)
   );

endmodule

// File: tb/tb_lcd_seq.sv
// Bench for lcd_seq: two instances (leading zeros shown / blanked) share
// the same stimulus. A per-instance bus monitor turns every LCD write into
// a record {stable, rs, db, setup, e_high, wait}; the main process compares
// those records against expectations from a hand table and from a
// character-level reference model.
module tb_lcd_seq;

   localparam int ND = 4;
   localparam int SU = 1;
   localparam int EC = 2;
   localparam int WC = 3;
   localparam int CC = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          update = 1'b0;
   logic [15:0]   digits = 16'h0;
   logic          busy [2];
   logic          ready [2];
   logic          done [2];
   logic          e [2];
   logic          rs [2];
   logic          rw [2];
   logic [7:0]    db [2];

   int checks = 0;
   int errors = 0;

   logic [8:0] exp0 [$];
   logic [8:0] exp1 [$];

   always #5 clk = ~clk;

   lcd_seq #(.NUM_DIGITS(ND), .SETUP_CYC(SU), .E_CYC(EC), .WAIT_CYC(WC),
             .CLR_WAIT_CYC(CC), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .update(update), .digits(digits),
      .busy(busy[0]), .ready(ready[0]), .done(done[0]), .lcd_e(e[0]),
      .lcd_rs(rs[0]), .lcd_rw(rw[0]), .lcd_db(db[0]));

   lcd_seq #(.NUM_DIGITS(ND), .SETUP_CYC(SU), .E_CYC(EC), .WAIT_CYC(WC),
             .CLR_WAIT_CYC(CC), .LZ_BLANK(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .update(update), .digits(digits),
      .busy(busy[1]), .ready(ready[1]), .done(done[1]), .lcd_e(e[1]),
      .lcd_rs(rs[1]), .lcd_rw(rw[1]), .lcd_db(db[1]));

   // Bus monitors: a write starts when DB leaves 0xCC and ends when it returns.
   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      logic [33:0] mem [0:511];
      int          cnt = 0;
      int          dcnt = 0;
      logic [1:0]  ph = 2'd0;
      logic [7:0]  cdb = 8'h0;
      logic        crs = 1'b0;
      logic [7:0]  pre = 8'h0;
      logic [7:0]  hi = 8'h0;
      logic [7:0]  post = 8'h0;
      logic        stab = 1'b1;

      always @(negedge clk) begin
         if (done[gi]) dcnt <= dcnt + 1;
         if (!rst_n) begin
            ph <= 2'd0;
         end else begin
            case (ph)
               2'd0: if (db[gi] != 8'hCC) begin
                  ph <= 2'd1; cdb <= db[gi]; crs <= rs[gi]; pre <= 8'd1; stab <= 1'b1;
               end
               2'd1: begin
                  if (db[gi] != cdb || rs[gi] != crs) stab <= 1'b0;
                  if (e[gi]) begin ph <= 2'd2; hi <= 8'd1; end
                  else pre <= pre + 8'd1;
               end
               2'd2: begin
                  if (db[gi] != cdb || rs[gi] != crs) stab <= 1'b0;
                  if (e[gi]) hi <= hi + 8'd1;
                  else begin ph <= 2'd3; post <= 8'd1; end
               end
               default: begin
                  if (db[gi] == 8'hCC && !e[gi]) begin
                     mem[cnt[8:0]] <= {stab, crs, cdb, pre, hi, post};
                     cnt <= cnt + 1;
                     ph <= 2'd0;
                  end else begin
                     if (db[gi] != cdb || rs[gi] != crs || e[gi]) stab <= 1'b0;
                     post <= post + 8'd1;
                  end
               end
            endcase
         end
      end
   end

   function automatic logic [33:0] rec(input int inst, input int idx);
      if (inst == 0) return g_mon[0].mem[idx[8:0]];
      return g_mon[1].mem[idx[8:0]];
   endfunction

   function automatic int lcnt(input int inst);
      return (inst == 0) ? g_mon[0].cnt : g_mon[1].cnt;
   endfunction

   function automatic int dcount(input int inst);
      return (inst == 0) ? g_mon[0].dcnt : g_mon[1].dcnt;
   endfunction

   // Reference: character shown at position pos (0 = leftmost).
   function automatic logic [7:0] model_char(input logic [15:0] d, input int pos, input bit lz);
      int v;
      bit zeros_so_far;
      v = int'((d >> (4 * (ND - 1 - pos))) & 16'hF);
      zeros_so_far = 1'b1;
      for (int p = 0; p <= pos; p++)
         if (((d >> (4 * (ND - 1 - p))) & 16'hF) != 16'h0) zeros_so_far = 1'b0;
      if (lz && pos != ND - 1 && zeros_so_far) return 8'h20;
      if (v < 10) return 8'(48 + v);
      return 8'(65 + v - 10);
   endfunction

   task automatic push_init();
      logic [7:0] cmds [4];
      cmds = '{8'h38, 8'h06, 8'h0E, 8'h01};
      for (int i = 0; i < 4; i++) begin
         exp0.push_back({1'b0, cmds[i]});
         exp1.push_back({1'b0, cmds[i]});
      end
   endtask

   task automatic push_refresh(input logic [15:0] d);
      exp0.push_back(9'h080);
      exp1.push_back(9'h080);
      for (int p = 0; p < ND; p++) begin
         exp0.push_back({1'b1, model_char(d, p, 1'b0)});
         exp1.push_back({1'b1, model_char(d, p, 1'b1)});
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_log(input string name, input int b0, input int b1);
      int base, n, ne;
      logic [8:0]  ex;
      logic [33:0] r;
      for (int inst = 0; inst < 2; inst++) begin
         base = (inst == 0) ? b0 : b1;
         n    = lcnt(inst) - base;
         ne   = (inst == 0) ? exp0.size() : exp1.size();
         chk($sformatf("%s_i%0d_nbytes", name, inst), 32'(n), 32'(ne));
         for (int i = 0; i < n && i < ne; i++) begin
            ex = (inst == 0) ? exp0[i] : exp1[i];
            r  = rec(inst, base + i);
            chk($sformatf("%s_i%0d_b%0d_rsdb", name, inst, i), 32'(r[32:24]), 32'(ex));
            chk($sformatf("%s_i%0d_b%0d_setup", name, inst, i), 32'(r[23:16]), 32'(SU));
            chk($sformatf("%s_i%0d_b%0d_ehigh", name, inst, i), 32'(r[15:8]), 32'(EC));
            chk($sformatf("%s_i%0d_b%0d_wait", name, inst, i), 32'(r[7:0]),
                (ex == 9'h001) ? 32'(CC) : 32'(WC));
            chk($sformatf("%s_i%0d_b%0d_stable", name, inst, i), 32'(r[33]), 32'd1);
         end
      end
      $display("txn %s: bytes_i0=%0d bytes_i1=%0d", name, lcnt(0) - b0, lcnt(1) - b1);
      exp0.delete();
      exp1.delete();
   endtask

   task automatic wait_done(input string name, input int limit);
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         if (done[0]) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_done_in_%0d_cycles required=done_pulse", name, limit);
      end
   endtask

   task automatic pulse_update(input logic [15:0] d);
      @(negedge clk);
      digits = d;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic run_refresh(input string name, input logic [15:0] d);
      int b0, b1, d0, d1;
      b0 = lcnt(0); b1 = lcnt(1); d0 = dcount(0); d1 = dcount(1);
      pulse_update(d);
      wait_done(name, 400);
      repeat (4) @(negedge clk);
      push_refresh(d);
      check_log(name, b0, b1);
      chk({name, "_done0"}, 32'(dcount(0) - d0), 32'd1);
      chk({name, "_done1"}, 32'(dcount(1) - d1), 32'd1);
   endtask

   typedef struct {
      logic [15:0] d;
      logic [39:0] plain;
      logic [39:0] blank;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      int   b0, b1, d0, d1, lat;
      logic [15:0] rnd;

      vecs[0] = '{16'h12AF, 40'h80_31_32_41_46, 40'h80_31_32_41_46};
      vecs[1] = '{16'h0070, 40'h80_30_30_37_30, 40'h80_20_20_37_30};
      vecs[2] = '{16'h0000, 40'h80_30_30_30_30, 40'h80_20_20_20_30};
      vecs[3] = '{16'hF00D, 40'h80_46_30_30_44, 40'h80_46_30_30_44};
      vecs[4] = '{16'h0009, 40'h80_30_30_30_39, 40'h80_20_20_20_39};
      vecs[5] = '{16'h0B0C, 40'h80_30_42_30_43, 40'h80_20_42_30_43};

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_busy_i%0d", i), 32'(busy[i]), 32'd0);
         chk($sformatf("rst_ready_i%0d", i), 32'(ready[i]), 32'd0);
         chk($sformatf("rst_done_i%0d", i), 32'(done[i]), 32'd0);
         chk($sformatf("rst_e_i%0d", i), 32'(e[i]), 32'd0);
         chk($sformatf("rst_rs_i%0d", i), 32'(rs[i]), 32'd0);
         chk($sformatf("rst_rw_i%0d", i), 32'(rw[i]), 32'd0);
         chk($sformatf("rst_db_i%0d", i), 32'(db[i]), 32'hCC);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // update before init is ignored
      b0 = lcnt(0); d0 = dcount(0);
      pulse_update(16'h1234);
      repeat (30) @(negedge clk);
      chk("idle_update_bytes", 32'(lcnt(0) - b0), 32'd0);
      chk("idle_update_done", 32'(dcount(0) - d0), 32'd0);
      chk("idle_update_busy", 32'(busy[0]), 32'd0);
      $display("txn idle_update: ignored");

      // init: first E rise SU+1 cycles after the accepting edge
      b0 = lcnt(0); b1 = lcnt(1); d0 = dcount(0); d1 = dcount(1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!e[0] && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("init_latency", 32'(lat), 32'(SU + 1));
      chk("init_busy", 32'(busy[0]), 32'd1);
      wait_done("init", 500);
      repeat (4) @(negedge clk);
      push_init();
      check_log("init", b0, b1);
      chk("init_done0", 32'(dcount(0) - d0), 32'd1);
      chk("init_done1", 32'(dcount(1) - d1), 32'd1);
      chk("init_ready0", 32'(ready[0]), 32'd1);
      chk("init_ready1", 32'(ready[1]), 32'd1);
      chk("init_busy_after", 32'(busy[0]), 32'd0);

      // Table-driven refreshes: hand-computed bytes for both blanking modes
      for (int t = 0; t < 6; t++) begin
         b0 = lcnt(0); b1 = lcnt(1);
         pulse_update(vecs[t].d);
         wait_done($sformatf("tbl%0d", t), 400);
         repeat (4) @(negedge clk);
         exp0.push_back(9'h080);
         exp1.push_back(9'h080);
         for (int k = 1; k < 5; k++) begin
            exp0.push_back({1'b1, vecs[t].plain[39-8*k -: 8]});
            exp1.push_back({1'b1, vecs[t].blank[39-8*k -: 8]});
         end
         check_log($sformatf("tbl%0d_%04h", t, vecs[t].d), b0, b1);
      end

      // Randomized refreshes against the reference model
      for (int t = 0; t < 12; t++) begin
         rnd = 16'($urandom);
         if (t % 3 == 0) rnd = rnd & 16'h00FF;   // bias toward leading zeros
         run_refresh($sformatf("rnd%0d_%04h", t, rnd), rnd);
      end

      // Three updates during one refresh -> exactly one extra refresh,
      // using the digits present when it starts
      b0 = lcnt(0); b1 = lcnt(1); d0 = dcount(0); d1 = dcount(1);
      pulse_update(16'h0A05);
      repeat (8) @(negedge clk);
      pulse_update(16'h1111);
      repeat (8) @(negedge clk);
      pulse_update(16'h2222);
      repeat (8) @(negedge clk);
      pulse_update(16'h00C3);
      wait_done("pend_first", 400);
      @(negedge clk);
      @(negedge clk);
      digits = 16'h9999;
      wait_done("pend_second", 400);
      repeat (60) @(negedge clk);
      push_refresh(16'h0A05);
      push_refresh(16'h00C3);
      check_log("pending_merge", b0, b1);
      chk("pending_done0", 32'(dcount(0) - d0), 32'd2);
      chk("pending_done1", 32'(dcount(1) - d1), 32'd2);

      // start and update together in READY: init only
      b0 = lcnt(0); b1 = lcnt(1); d0 = dcount(0);
      @(negedge clk);
      digits = 16'h5555;
      start = 1'b1;
      update = 1'b1;
      @(negedge clk);
      start = 1'b0;
      update = 1'b0;
      wait_done("start_upd", 500);
      repeat (60) @(negedge clk);
      push_init();
      check_log("start_and_update", b0, b1);
      chk("start_upd_done", 32'(dcount(0) - d0), 32'd1);
      chk("start_upd_ready", 32'(ready[0]), 32'd1);

      // Asynchronous reset while E is high
      pulse_update(16'h4321);
      lat = 0;
      while (!e[0] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("midrst_e_seen", 32'(e[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("midrst_e_i%0d", i), 32'(e[i]), 32'd0);
         chk($sformatf("midrst_db_i%0d", i), 32'(db[i]), 32'hCC);
         chk($sformatf("midrst_rs_i%0d", i), 32'(rs[i]), 32'd0);
         chk($sformatf("midrst_busy_i%0d", i), 32'(busy[i]), 32'd0);
         chk($sformatf("midrst_ready_i%0d", i), 32'(ready[i]), 32'd0);
         chk($sformatf("midrst_done_i%0d", i), 32'(done[i]), 32'd0);
      end
      $display("txn mid_transfer_reset: applied");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_busy", 32'(busy[0]), 32'd0);
      chk("post_rst_ready", 32'(ready[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
